// File: rtl/bin_to_bcd16.sv
// bin_to_bcd16: sequential double-dabble binary-to-BCD converter.
// Converts one input bit per clock. It uses a start/busy/done handshake.
// The bcd output holds the last completed result until the next
// conversion finishes or reset is applied.
module bin_to_bcd16 #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t                r_state;
  logic                  r_busy;
  logic                  r_done;
  logic [4*DIGITS-1:0]   r_bcd;
  logic [WIDTH-1:0]      r_sh;
  logic [4*DIGITS-1:0]   r_d;
  logic [CNT_W-1:0]      r_cnt;

  logic [4*DIGITS-1:0]   w_d_adj;
  logic [4*DIGITS-1:0]   w_d_next;
  logic [WIDTH-1:0]      w_sh_next;

  // Add 3 to every digit that is 5 or more, so the next left shift carries into the next decimal digit.
  // Each digit is at most 9 before the adjustment, so the 4-bit sum cannot overflow.
  function automatic logic [4*DIGITS-1:0] add3_digits(input logic [4*DIGITS-1:0] d);
    logic [4*DIGITS-1:0] r;
    r = d;
    for (int i = 0; i < DIGITS; i++) begin
      if (d[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = d[4*i +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

  // Adjust the digits, then shift {digits, binary} left by one bit.
  always_comb begin
    w_d_adj   = add3_digits(r_d);
    w_d_next  = {w_d_adj[4*DIGITS-2:0], r_sh[WIDTH-1]};
    w_sh_next = {r_sh[WIDTH-2:0], 1'b0};
  end

  // Control FSM, shift datapath and result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_bcd   <= '0;
      r_sh    <= '0;
      r_d     <= '0;
      r_cnt   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_sh    <= bin;
            r_d     <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          r_sh <= w_sh_next;
          r_d  <= w_d_next;
          if (r_cnt == LAST) begin
            // The WIDTH-th shift finishes the conversion, so publish it straight from the shifter.
            r_bcd   <= w_d_next;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign bcd  = r_bcd;

endmodule

// File: doc/bin_to_bcd16.md
Name: bin_to_bcd16

Overview:
- Sequential binary-to-BCD converter using the shift-add-3 (double-dabble) algorithm.
- Sits directly downstream of the 8x8 shift-add multiplier. It takes the 16-bit product and produces five packed BCD digits for the seven-segment display driver.
- Converts one input bit per clock, with a start/busy/done handshake.
- The output register holds the last converted value until the next conversion completes.

Parameters:
- WIDTH, 16, binary input width in bits.
- DIGITS, 5, number of BCD digits output. Must satisfy 10^DIGITS > 2^WIDTH-1.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request a conversion; sampled only in IDLE.
- bin  input  WIDTH  binary value; captured on the accepting edge.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when bcd has just been updated.
- bcd  output  4*DIGITS  packed BCD result; bcd[3:0] = ones, bcd[19:16] = ten-thousands.

Interface note: one clock; reset is synchronous and active-high.

Behaviour:
- Reset (rst=1 at a rising edge): state=IDLE, busy=0, done=0, bcd=0, internal shift and digit registers cleared, bit counter=0. Reset overrides all other inputs. A reset mid-conversion aborts it, with no done pulse and bcd=0.
- States: IDLE, SHIFT.
- IDLE, start=1 at edge k:
  - capture bin into shift register sh[WIDTH-1:0];
  - clear digit register d[4*DIGITS-1:0]; count=0;
  - go to SHIFT; busy=1 from edge k.
- IDLE, start=0: hold; busy=0.
- SHIFT, each edge:
  - for every 4-bit digit of d, if digit>=5 add 3 (combinational, all digits in parallel, using current d);
  - shift {d_adj, sh} left by 1: the MSB of sh enters d bit 0, and sh is filled with 0;
  - count increments.
  - Edge where count==WIDTH-1 (the WIDTH-th shift): the shifted result is written to bcd, done=1 for exactly that cycle, busy=0, state=IDLE.
- Latency: start accepted at edge k gives bcd valid and done high after edge k+WIDTH (16 cycles for the default).
- done is deasserted on every edge except the completing one.
- start while busy: ignored; bin changes during busy have no effect.
- Back-to-back: start=1 in the cycle done is high is accepted (state is IDLE). The new conversion's done follows WIDTH cycles later, and bcd holds the previous result until then.
- bcd changes only on a completing edge or on reset.
- Digit add-3 never overflows a 4-bit digit (input to add-3 is at most 9). No carry logic between digits is required beyond the shift.
- Count width is clog2(WIDTH); it wraps to 0 on returning to IDLE.

Test Plan:
- Reset, then start with bin=0 -> done after 16 cycles, bcd=0x00000; busy high for exactly 16 cycles.
- bin=16'hFFFF (65535) -> bcd=0x65535. bin=16'hFE01 (255*255=65025, the maximum multiplier product) -> bcd=0x65025.
- bin=9999 then immediately bin=10000 (start re-asserted in the done cycle) -> first done shows bcd=0x09999. Second done, exactly 16 cycles later, shows bcd=0x10000.
- Start with bin=1234; at cycle 5 assert start with bin=4321 -> second start ignored; done once at cycle 16 with bcd=0x01234.
- Start with bin=500 after a prior result of 0x00042; assert rst at cycle 8 -> busy=0 and bcd=0 next cycle. No done pulse; a subsequent start with bin=500 yields 0x00500.
- Hold start=0 for 50 cycles after a result -> bcd stable, done and busy stay 0.
